// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-image loader.
// Optional checksum stage is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage

// File: rtl/prog_loader_ctrl_packer.sv
// Assembles little-endian 32-bit words from a byte stream; the first byte
// of each word lands in bits 7:0. word_valid_o pulses the cycle after byte 4.
module byte_word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q;
    logic        word_valid_q;

    assign word_last_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[31:8]};
        end
    end

    // word_q is a separate copy so the write data stays stable while the
    // next word's bytes are already shifting in.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_valid_q <= word_last_o;
            if (word_last_o) begin
                word_q <= shift_d;
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot loader: holds the core idle, streams a length-prefixed image into
// instruction memory, then releases it. PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_run,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    state_e             state_q;
    logic               rx_ready_q;
    logic               cpu_run_q;
    logic               load_done_q;
    logic               load_err_q;
    logic [15:0]        len_q;
    logic [15:0]        words_loaded_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic [31:0]        imem_addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    logic               rx_fire;
    logic               byte_in_data;
    logic               word_last;
    logic               last_word;
    logic [15:0]        hdr_len;

    assign rx_fire      = rx_valid && rx_ready_q;
    assign byte_in_data = rx_fire && (state_q == DATA);
    assign hdr_len      = {rx_data, len_q[7:0]};
    assign last_word    = (words_loaded_q + 16'd1) == len_q;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (byte_in_data),
        .byte_i       (rx_data),
        .word_last_o  (word_last),
        .word_valid_o (imem_we),
        .word_o       (imem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LEN_LO;
            rx_ready_q     <= 1'b1;
            cpu_run_q      <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            len_q          <= '0;
            words_loaded_q <= '0;
            word_idx_q     <= '0;
            imem_addr_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            case (state_q)
                LEN_LO: begin
                    if (rx_fire) begin
                        len_q   <= {8'h00, rx_data};
                        state_q <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_fire) begin
                        len_q <= hdr_len;
                        if (hdr_len == '0) begin
                            state_q     <= DONE;
                            rx_ready_q  <= 1'b0;
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                        end else if (hdr_len > 16'(MEM_WORDS)) begin
                            state_q    <= ERR;
                            rx_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (rx_fire) begin
                        csum_q <= csum_q ^ rx_data;
                    end
`endif
                    // Address and count register alongside the packer's
                    // write strobe, so all three appear together next cycle.
                    if (word_last) begin
                        imem_addr_q    <= word_to_byte_addr(32'(word_idx_q));
                        words_loaded_q <= words_loaded_q + 16'd1;
                        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
`endif
                        end else begin
                            word_idx_q <= word_idx_q + IDX_W'(1);
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (rx_fire) begin
                        rx_ready_q <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q     <= DONE;
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    if (reload) begin
                        state_q        <= LEN_LO;
                        rx_ready_q     <= 1'b1;
                        cpu_run_q      <= 1'b0;
                        load_done_q    <= 1'b0;
                        load_err_q     <= 1'b0;
                        len_q          <= '0;
                        words_loaded_q <= '0;
                        word_idx_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q         <= '0;
`endif
                    end else if (state_q == DONE) begin
                        // Entering DONE from DATA lands on the final write
                        // cycle; the core is released one cycle later.
                        cpu_run_q   <= 1'b1;
                        load_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= LEN_LO;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign cpu_run      = cpu_run_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;
    assign imem_addr    = imem_addr_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl with a queue-based image model.
// Follows PROG_LOADER_CHECKSUM_EN so it matches either build of the design.
module tb_prog_loader_ctrl;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        reload = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    prog_loader_ctrl #(.MEM_WORDS(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] img[$];
    int          last_we_cyc = -1;
    int          run_rise_cyc = -1;
    int          last_acc_cyc = -1;
    int          stalls = 0;
    logic        prev_run = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (cpu_run && !prev_run) run_rise_cyc = cyc;
        prev_run = cpu_run;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        last_we_cyc  = -1;
        run_rise_cyc = -1;
        stalls       = 0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_ready && n < 40) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept data=%02h rx_ready=%b want 1", b, rx_ready);
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Streams img as header, little-endian words and (if enabled) XOR checksum.
    task automatic send_image(input int unsigned gap_max);
        logic [15:0] n;
        logic [31:0] w;
        logic [7:0]  cs;
        n  = 16'(img.size());
        cs = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        foreach (img[i]) begin
            w = img[i];
            for (int unsigned k = 0; k < 4; k++) begin
                if (gap_max > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, gap_max));
                send_byte(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (img.size() > 0) send_byte(cs);
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (!(load_done || load_err) && n < 30) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done load_done=%b load_err=%b want done=1", load_done, load_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_ready, cpu_run, load_done, load_err} !== 4'b1000 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL reload_clear rdy/run/done/err=%b%b%b%b wl=%0d want 1000 wl=0",
                     rx_ready, cpu_run, load_done, load_err, words_loaded);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_ready, imem_we, cpu_run, load_done, load_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags rdy/we/run/done/err=%b%b%b%b%b want 10000",
                     rx_ready, imem_we, cpu_run, load_done, load_err);
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            errors++;
            $display("FAIL reset_values addr=%h data=%h wl=%0d want 0 0 0", imem_addr, imem_wdata, words_loaded);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_mon();
        img = '{32'h0000_0013, 32'h0010_0093};
        send_image(0);
        wait_end();
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL basic_count got %0d writes want 2", wr_addr.size());
        end
        for (int unsigned i = 0; i < 2 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== img[i]) begin
                errors++;
                $display("FAIL basic_write%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], 32'(i * 4), img[i]);
            end
        end
        checks++;
        if (run_rise_cyc !== last_we_cyc + 1) begin
            errors++;
            $display("FAIL basic_run_timing rise=%0d want %0d", run_rise_cyc, last_we_cyc + 1);
        end
        checks++;
        if (words_loaded !== 16'd2 || rx_ready !== 1'b0 || stalls !== 0) begin
            errors++;
            $display("FAIL basic_final wl=%0d rdy=%b stalls=%0d want 2 0 0", words_loaded, rx_ready, stalls);
        end
        pulse_reload();
    endtask

    task automatic test_zero_len();
        int hdr;
        clear_mon();
        send_byte(8'h00);
        send_byte(8'h00);
        hdr = last_acc_cyc;
        idle(3);
        checks++;
        if (wr_addr.size() !== 0 || load_done !== 1'b1 || cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL zero_len writes=%0d done=%b run=%b want 0 1 1", wr_addr.size(), load_done, cpu_run);
        end
        checks++;
        if (run_rise_cyc !== hdr + 1) begin
            errors++;
            $display("FAIL zero_len_timing rise=%0d want %0d", run_rise_cyc, hdr + 1);
        end
        pulse_reload();
    endtask

    task automatic test_oversize();
        clear_mon();
        send_byte(8'(MW + 1));
        send_byte(8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        idle(4);
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_err, cpu_run, load_done, rx_ready} !== 4'b1000 || wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL oversize err/run/done/rdy=%b%b%b%b writes=%0d want 1000 0",
                     load_err, cpu_run, load_done, rx_ready, wr_addr.size());
        end
        @(posedge clk);
        #1;
        pulse_reload();
        clear_mon();
        img = '{$urandom()};
        send_image(0);
        wait_end();
        checks++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== img[0]) begin
            errors++;
            $display("FAIL oversize_recover writes=%0d want 1 word %h at 0", wr_addr.size(), img[0]);
        end
        pulse_reload();
    endtask

    task automatic test_mid_reset();
        logic [31:0] w0;
        clear_mon();
        w0 = $urandom();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int unsigned k = 0; k < 4; k++) send_byte(w0[8*k +: 8]);
        send_byte(8'h5A);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_addr.size() !== 1 || wr_data[0] !== w0 || wr_addr[0] !== 32'h0) begin
            errors++;
            $display("FAIL midrst_writes got %0d writes want 1 of %h at 0", wr_addr.size(), w0);
        end
        checks++;
        if ({rx_ready, imem_we, cpu_run, load_done, load_err} !== 5'b10000 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state rdy/we/run/done/err=%b%b%b%b%b wl=%0d want 10000 0",
                     rx_ready, imem_we, cpu_run, load_done, load_err, words_loaded);
        end
        @(posedge clk);
        #1;
        clear_mon();
        img = '{$urandom()};
        send_image(0);
        wait_end();
        checks++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== img[0]) begin
            errors++;
            $display("FAIL midrst_fresh writes=%0d want 1 word %h at 0", wr_addr.size(), img[0]);
        end
        pulse_reload();
    endtask

    task automatic test_gaps_random();
        logic [31:0] ref_data[$];
        int unsigned n;
        for (int unsigned it = 0; it < 6; it++) begin
            n = $urandom_range(1, MW);
            ref_data.delete();
            for (int unsigned i = 0; i < n; i++) ref_data.push_back($urandom());
            for (int unsigned pass = 0; pass < 2; pass++) begin
                clear_mon();
                img = ref_data;
                send_image(pass == 0 ? 0 : 3);
                wait_end();
                checks++;
                if (wr_addr.size() !== int'(n)) begin
                    errors++;
                    $display("FAIL rand%0d_p%0d_count got %0d want %0d", it, pass, wr_addr.size(), n);
                end
                for (int unsigned i = 0; i < n && i < wr_addr.size(); i++) begin
                    checks++;
                    if (wr_addr[i] !== 32'(i << 2) || wr_data[i] !== ref_data[i]) begin
                        errors++;
                        $display("FAIL rand%0d_p%0d_w%0d got %h/%h want %h/%h", it, pass, i,
                                 wr_addr[i], wr_data[i], 32'(i << 2), ref_data[i]);
                    end
                end
                checks++;
                if (words_loaded !== 16'(n) || run_rise_cyc !== last_we_cyc + 1) begin
                    errors++;
                    $display("FAIL rand%0d_p%0d_end wl=%0d rise=%0d want %0d %0d", it, pass,
                             words_loaded, run_rise_cyc, n, last_we_cyc + 1);
                end
                if (pass == 0) begin
                    checks++;
                    if (stalls !== 0) begin
                        errors++;
                        $display("FAIL rand%0d_throughput stalls=%0d want 0", it, stalls);
                    end
                end
                pulse_reload();
            end
        end
    endtask

    task automatic test_reload_ignored();
        logic [31:0] w;
        clear_mon();
        img = '{$urandom(), $urandom()};
        send_byte(8'h02);
        send_byte(8'h00);
        reload = 1'b1;
        idle(1);
        reload = 1'b0;
        foreach (img[i]) begin
            w = img[i];
            for (int unsigned k = 0; k < 4; k++) begin
                if (i == 0 && k == 2) begin
                    reload = 1'b1;
                    idle(1);
                    reload = 1'b0;
                end
                send_byte(w[8*k +: 8]);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(img[0][7:0] ^ img[0][15:8] ^ img[0][23:16] ^ img[0][31:24] ^
                  img[1][7:0] ^ img[1][15:8] ^ img[1][23:16] ^ img[1][31:24]);
`endif
        wait_end();
        checks++;
        if (wr_addr.size() !== 2 || wr_data[0] !== img[0] || wr_data[1] !== img[1] || wr_addr[1] !== 32'h4) begin
            errors++;
            $display("FAIL reload_ignored writes=%0d want 2 words %h %h", wr_addr.size(), img[0], img[1]);
        end
        pulse_reload();
    endtask

    task automatic test_max_image();
        clear_mon();
        img.delete();
        for (int unsigned i = 0; i < MW; i++) img.push_back($urandom());
        send_image(0);
        wait_end();
        idle(3);
        checks++;
        if (wr_addr.size() !== int'(MW) || wr_addr[MW-1] !== 32'((MW - 1) * 4)) begin
            errors++;
            $display("FAIL max_last writes=%0d want %0d ending at %h", wr_addr.size(), MW, 32'((MW - 1) * 4));
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'((MW - 1) * 4) || imem_wdata !== img[MW-1] || words_loaded !== 16'(MW)) begin
            errors++;
            $display("FAIL max_hold addr=%h data=%h wl=%0d want %h %h %0d", imem_addr, imem_wdata,
                     words_loaded, 32'((MW - 1) * 4), img[MW-1], MW);
        end
        @(posedge clk);
        #1;
        pulse_reload();
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int unsigned bad = 0; bad < 2; bad++) begin
            clear_mon();
            send_byte(8'h01);
            send_byte(8'h00);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
            send_byte(8'h04);
            send_byte(bad == 0 ? 8'h04 : 8'h05);
            idle(2);
            checks++;
            if (load_done !== (bad == 0) || load_err !== (bad == 1) || cpu_run !== (bad == 0)) begin
                errors++;
                $display("FAIL csum_bad%0d done=%b err=%b run=%b", bad, load_done, load_err, cpu_run);
            end
            checks++;
            if (wr_addr.size() !== 1 || wr_data[0] !== 32'h0403_0201) begin
                errors++;
                $display("FAIL csum_write%0d writes=%0d want 1 of 04030201", bad, wr_addr.size());
            end
            pulse_reload();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_oversize();
        test_mid_reset();
        test_gaps_random();
        test_reload_ignored();
        test_max_image();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
- Boot-time controller that sequences the single-cycle core: holds the core idle, streams a program image from an 8-bit byte link into instruction memory, then releases the core.
- Sits between the host/UART byte receiver and the instruction-memory write port.
- Drives the core's run enable.

Parameters:
- MEM_WORDS, 1024, instruction-memory depth in 32-bit words; maximum accepted image length.
- IDX_W, $clog2(MEM_WORDS), width of the internal word index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  controller accepts a byte this cycle. Transfer occurs when rx_valid && rx_ready.
- reload  in  1  one-cycle request to reload from DONE or ERR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address = word_idx << 2.
- imem_wdata  out  32  assembled little-endian word.
- cpu_run  out  1  core enabled; 0 while loading or in error.
- load_done  out  1  image loaded successfully.
- load_err  out  1  image rejected.
- words_loaded  out  16  count of words written this load.

Behaviour:
- Reset: state LEN_LO, all outputs 0 except rx_ready=1; counters, assembly register and checksum cleared. Reset mid-load aborts the load; no further imem_we until a new header is received.
- Image format: 2-byte little-endian word count N (LEN_LO, then LEN_HI), then N*4 bytes, each word little-endian (first byte → bits 7:0).
- States:
  - LEN_LO: latch the low byte, go to LEN_HI.
  - LEN_HI: latch the high byte, then branch:
    - N==0 → DONE.
    - N>MEM_WORDS → ERR.
    - otherwise → DATA.
  - DATA: a 2-bit byte counter shifts bytes into the assembly register.
    - On the 4th byte accepted at cycle T: imem_we=1 at T+1 with imem_addr = word_idx*4 and imem_wdata = the assembled word.
    - word_idx and words_loaded increment at T+1.
    - rx_ready stays 1 during the write cycle, so a byte per cycle is sustained.
  - Final byte of word N-1 → DONE (or CSUM when the optional feature is enabled).
  - DONE: rx_ready=0, load_done=1, cpu_run=1. cpu_run rises the cycle after the final imem_we pulse; for N==0 it rises the cycle after LEN_HI is accepted.
  - ERR: rx_ready=0, load_err=1, cpu_run=0.
- reload: honoured only in DONE or ERR. Next cycle: state LEN_LO, cpu_run, load_done and load_err = 0, counters cleared. Ignored in every other state.
- rx_valid while rx_ready=0 is ignored; no data is lost to the controller, and the source holds the byte.
- imem_we never asserts outside DATA → DONE/CSUM completion. imem_addr and imem_wdata hold their last value when imem_we=0.
- Maximum image N==MEM_WORDS: last write address (MEM_WORDS-1)*4; word_idx does not wrap.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- With the macro: a running XOR of all payload bytes (header excluded) is kept. After the last data byte the state is CSUM, which accepts one byte.
  - Match → DONE; cpu_run rises the cycle after the checksum byte is accepted, which is at or after the final write.
  - Mismatch → ERR. Words already written remain in memory.
- Without the macro: there is no CSUM state and DATA goes directly to DONE.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enumeration (LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - the header byte count constant (2);
  - the bytes-per-word constant (4).
- One sub-module, byte_word_packer: 2-bit counter plus 32-bit shift register with a word_valid pulse. The top-level FSM owns address, count and flags.

Test Plan:
- Reset, send header 02 00, then bytes 13 00 00 00 93 00 10 00 → imem_we pulses: addr 0x0 data 0x00000013, addr 0x4 data 0x00100093. cpu_run=1 the cycle after the second write; words_loaded=2; rx_ready=0.
- Header 00 00 → no imem_we; load_done=1 and cpu_run=1 the cycle after LEN_HI.
- With MEM_WORDS=4, header 05 00 → load_err=1, cpu_run=0, no writes. Pulse reload, then send a valid 1-word image → load_done=1.
- Assert rst after 5 payload bytes of a 2-word image → one write (addr 0) occurred, outputs return to reset values. A fresh 1-word image loads at addr 0.
- rx_valid toggled with gaps plus back-to-back bytes across a word boundary → identical imem writes to the gap-free run; one byte accepted per cycle during the write cycle.
- PROG_LOADER_CHECKSUM_EN: 1-word image 01 02 03 04 followed by checksum 04 → DONE. Same image followed by 05 → ERR with load_err=1.
